// File: rtl/otter_io_pkg.sv
// Shared constants for the OTTER IO timer: register map, CTRL layout, default base.
package otter_io_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1100_0400;

  localparam logic [1:0] IDX_CTRL   = 2'd0;
  localparam logic [1:0] IDX_COUNT  = 2'd1;
  localparam logic [1:0] IDX_RELOAD = 2'd2;
  localparam logic [1:0] IDX_STATUS = 2'd3;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_AUTO_BIT = 1;
  localparam int CTRL_IE_BIT   = 2;

  localparam int PRESCALE_LSB = 8;
  localparam int PRESCALE_MSB = 15;
  localparam int PRESCALE_W   = PRESCALE_MSB - PRESCALE_LSB + 1;

  localparam int STATUS_PEND_BIT = 0;

  // Builds the CTRL readback word; unused bits always read as zero.
  function automatic logic [31:0] packCtrl(input logic en, input logic auto,
                                           input logic ie,
                                           input logic [PRESCALE_W-1:0] prescale);
    logic [31:0] word;
    word = '0;
    word[CTRL_EN_BIT]                = en;
    word[CTRL_AUTO_BIT]              = auto;
    word[CTRL_IE_BIT]                = ie;
    word[PRESCALE_MSB:PRESCALE_LSB]  = prescale;
    return word;
  endfunction

endpackage

// File: rtl/otter_io_timer_prescaler.sv
// Prescaler for the IO timer: emits a one-cycle TICK every PRESCALE+1 enabled cycles.
module tmr_prescaler
  import otter_io_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EN,
  input  logic                  CLR,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  output logic                  TICK
);

  logic [PRESCALE_W-1:0] r_pcnt;

  // Greater-or-equal so a PRESCALE lowered under the running count still ticks promptly.
  assign TICK = EN && (r_pcnt >= PRESCALE);

  // Count enabled cycles, restarting on a tick, a clear request, or while disabled.
  always_ff @(posedge CLK) begin
    if (RST || CLR || !EN || TICK) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + 1'b1;
    end
  end

endmodule

// File: rtl/otter_io_timer.sv
// Memory-mapped countdown timer on the OTTER IOBUS with prescaler, auto-reload and interrupt.
module otter_io_timer
  import otter_io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] RD_DATA,
  output logic        RD_HIT,
  output logic        INTR
);

  logic                  r_en;
  logic                  r_auto;
  logic                  r_ie;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [31:0]           r_count;
  logic [31:0]           r_reload;
  logic                  r_pend;

  logic       w_sel;
  logic [1:0] w_idx;
  logic       w_wrCtrl;
  logic       w_wrCount;
  logic       w_wrReload;
  logic       w_wrStatus;
  logic       w_tick;
  logic       w_expire;
  logic       w_pcntClr;
  logic       w_unusedAddr;

  assign w_sel        = (IOBUS_ADDR[31:4] == BASE_ADDR[31:4]);
  assign w_idx        = IOBUS_ADDR[3:2];
  assign w_unusedAddr = &{1'b0, IOBUS_ADDR[1:0]};

  assign w_wrCtrl   = IOBUS_WR && w_sel && (w_idx == IDX_CTRL);
  assign w_wrCount  = IOBUS_WR && w_sel && (w_idx == IDX_COUNT);
  assign w_wrReload = IOBUS_WR && w_sel && (w_idx == IDX_RELOAD);
  assign w_wrStatus = IOBUS_WR && w_sel && (w_idx == IDX_STATUS);

  assign w_expire  = w_tick && (r_count == 32'd0);
  assign w_pcntClr = w_wrCtrl || (w_wrCount && w_tick);

  tmr_prescaler u_prescaler (
    .CLK      (CLK),
    .RST      (RST),
    .EN       (r_en),
    .CLR      (w_pcntClr),
    .PRESCALE (r_prescale),
    .TICK     (w_tick)
  );

  // CTRL: software writes win over the one-shot hardware clear of EN.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_en       <= 1'b0;
      r_auto     <= 1'b0;
      r_ie       <= 1'b0;
      r_prescale <= '0;
    end else if (w_wrCtrl) begin
      r_en       <= IOBUS_OUT[CTRL_EN_BIT];
      r_auto     <= IOBUS_OUT[CTRL_AUTO_BIT];
      r_ie       <= IOBUS_OUT[CTRL_IE_BIT];
      r_prescale <= IOBUS_OUT[PRESCALE_MSB:PRESCALE_LSB];
    end else if (w_expire && !r_auto) begin
      r_en <= 1'b0;
    end
  end

  // COUNT: software write beats the tick; otherwise decrement or reload on expiry.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_count <= '0;
    end else if (w_wrCount) begin
      r_count <= IOBUS_OUT;
    end else if (w_tick) begin
      if (r_count != 32'd0) begin
        r_count <= r_count - 32'd1;
      end else if (r_auto) begin
        r_count <= r_reload;
      end
    end
  end

  // RELOAD is a plain software register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_reload <= '0;
    end else if (w_wrReload) begin
      r_reload <= IOBUS_OUT;
    end
  end

  // PEND: hardware set has priority over a coincident write-1-to-clear.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pend <= 1'b0;
    end else if (w_expire) begin
      r_pend <= 1'b1;
    end else if (w_wrStatus && IOBUS_OUT[STATUS_PEND_BIT]) begin
      r_pend <= 1'b0;
    end
  end

  // Side-effect-free read mux, zero outside the window.
  always_comb begin
    RD_DATA = '0;
    RD_HIT  = w_sel;
    if (w_sel) begin
      case (w_idx)
        IDX_CTRL:   RD_DATA = packCtrl(r_en, r_auto, r_ie, r_prescale);
        IDX_COUNT:  RD_DATA = r_count;
        IDX_RELOAD: RD_DATA = r_reload;
        default:    RD_DATA = {31'd0, r_pend};
      endcase
    end
  end

  assign INTR = r_pend & r_ie;

endmodule

// File: tb/tb_otter_io_timer.sv
// Self-checking bench for otter_io_timer: behavioural model plus directed literal checks.
module tb_otter_io_timer;

  localparam logic [31:0] BASE = 32'h1100_0400;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] RD_DATA;
  logic        RD_HIT;
  logic        INTR;

  int checks = 0;
  int errors = 0;
  bit cmpEn  = 1'b0;

  // Behavioural model state, the timer as software sees it.
  bit          mEn, mAuto, mIe, mPend;
  logic [7:0]  mPresc = 8'd0;
  logic [7:0]  mPcnt  = 8'd0;
  logic [31:0] mCount = 32'd0;
  logic [31:0] mReload = 32'd0;

  always #5 CLK = ~CLK;

  otter_io_timer #(.BASE_ADDR(BASE)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .IOBUS_ADDR (IOBUS_ADDR),
    .IOBUS_OUT  (IOBUS_OUT),
    .IOBUS_WR   (IOBUS_WR),
    .RD_DATA    (RD_DATA),
    .RD_HIT     (RD_HIT),
    .INTR       (INTR)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit mSel(input logic [31:0] a);
    return a[31:4] == BASE[31:4];
  endfunction

  function automatic logic [31:0] mRead(input logic [31:0] a);
    if (!mSel(a)) return 32'd0;
    case (a[3:2])
      2'd0:    return {16'd0, mPresc, 5'd0, mIe, mAuto, mEn};
      2'd1:    return mCount;
      2'd2:    return mReload;
      default: return {31'd0, mPend};
    endcase
  endfunction

  // Model: advance one clock from the inputs presented during the cycle.
  always @(posedge CLK) begin
    bit tick, expire, wrHit;
    logic [1:0] idx;
    if (RST) begin
      mEn = 0; mAuto = 0; mIe = 0; mPend = 0;
      mPresc = 0; mPcnt = 0; mCount = 0; mReload = 0;
    end else begin
      tick   = mEn && (mPcnt >= mPresc);
      expire = tick && (mCount == 0);
      wrHit  = IOBUS_WR && mSel(IOBUS_ADDR);
      idx    = IOBUS_ADDR[3:2];
      if (tick) mPcnt = 0;
      else if (mEn) mPcnt = mPcnt + 8'd1;
      else mPcnt = 0;
      if (tick) begin
        if (mCount != 0) mCount = mCount - 1;
        else if (mAuto) mCount = mReload;
        else mEn = 0;
      end
      if (wrHit && idx == 2'd3 && IOBUS_OUT[0]) mPend = 0;
      if (expire) mPend = 1;
      if (wrHit) begin
        case (idx)
          2'd0: begin
            mEn = IOBUS_OUT[0]; mAuto = IOBUS_OUT[1]; mIe = IOBUS_OUT[2];
            mPresc = IOBUS_OUT[15:8]; mPcnt = 0;
          end
          2'd1: mCount = IOBUS_OUT;
          2'd2: mReload = IOBUS_OUT;
          default: ;
        endcase
      end
    end
  end

  // Compare every cycle, mid-cycle, once the DUT has seen reset.
  always @(negedge CLK) begin
    if (cmpEn) begin
      checkOutput("rd_data", RD_DATA, mRead(IOBUS_ADDR));
      checkOutput("rd_hit", {31'd0, RD_HIT}, {31'd0, mSel(IOBUS_ADDR)});
      checkOutput("intr", {31'd0, INTR}, {31'd0, mPend & mIe});
    end
  end

  task automatic applyStimulus(input logic rst, input logic [31:0] addr,
                               input logic [31:0] data, input logic wr);
    @(posedge CLK);
    #2;
    RST = rst; IOBUS_ADDR = addr; IOBUS_OUT = data; IOBUS_WR = wr;
  endtask

  task automatic wrReg(input logic [1:0] idx, input logic [31:0] d);
    applyStimulus(1'b0, BASE + {28'd0, idx, 2'b00}, d, 1'b1);
  endtask

  task automatic readExpect(input logic [1:0] idx, input logic [31:0] exp, input string name);
    applyStimulus(1'b0, BASE + {28'd0, idx, 2'b00}, 32'd0, 1'b0);
    #1;
    checkOutput(name, RD_DATA, exp);
  endtask

  task automatic clearAll();
    wrReg(2'd0, 32'd0);
    wrReg(2'd3, 32'd1);
  endtask

  initial begin
    logic [31:0] addr, data;
    logic [1:0]  idx;
    int          r;
    RST = 1'b1; IOBUS_ADDR = 32'd0; IOBUS_OUT = 32'd0; IOBUS_WR = 1'b0;
    applyStimulus(1'b1, 32'd0, 32'd0, 1'b0);
    applyStimulus(1'b1, 32'd0, 32'd0, 1'b0);
    cmpEn = 1'b1;

    // Reset state
    readExpect(2'd0, 32'd0, "rst_ctrl");
    readExpect(2'd1, 32'd0, "rst_count");
    readExpect(2'd2, 32'd0, "rst_reload");
    readExpect(2'd3, 32'd0, "rst_status");
    checkOutput("rst_intr", {31'd0, INTR}, 32'd0);

    // Auto-reload with prescale 0
    wrReg(2'd2, 32'd3);
    wrReg(2'd1, 32'd3);
    wrReg(2'd0, 32'h0000_0007);
    readExpect(2'd1, 32'd3, "auto_start");
    readExpect(2'd1, 32'd2, "auto_c2");
    readExpect(2'd1, 32'd1, "auto_c1");
    readExpect(2'd1, 32'd0, "auto_c0");
    checkOutput("auto_intr_low", {31'd0, INTR}, 32'd0);
    readExpect(2'd1, 32'd3, "auto_reload");
    checkOutput("auto_intr_high", {31'd0, INTR}, 32'd1);
    readExpect(2'd1, 32'd2, "auto_rep2");
    readExpect(2'd1, 32'd1, "auto_rep1");
    readExpect(2'd1, 32'd0, "auto_rep0");
    readExpect(2'd1, 32'd3, "auto_rep_reload");
    readExpect(2'd3, 32'd1, "auto_pend");

    // W1C behaviour
    wrReg(2'd0, 32'h0000_0004);
    wrReg(2'd3, 32'd0);
    readExpect(2'd3, 32'd1, "w1c_zero_noeffect");
    wrReg(2'd3, 32'd1);
    readExpect(2'd3, 32'd0, "w1c_clear");
    checkOutput("w1c_intr", {31'd0, INTR}, 32'd0);
    wrReg(2'd1, 32'd0);
    wrReg(2'd2, 32'd0);
    wrReg(2'd0, 32'h0000_0007);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0);
    wrReg(2'd3, 32'd1);
    readExpect(2'd3, 32'd1, "w1c_vs_set");
    clearAll();

    // One-shot with prescale 4
    wrReg(2'd1, 32'd1);
    wrReg(2'd0, 32'h0000_0405);
    for (int k = 0; k < 12; k++) begin
      if (k == 4) readExpect(2'd1, 32'd1, "oneshot_cnt_before");
      else if (k == 5) readExpect(2'd1, 32'd0, "oneshot_cnt_after");
      else readExpect(2'd3, (k >= 10) ? 32'd1 : 32'd0, "oneshot_pend");
    end
    readExpect(2'd0, 32'h0000_0404, "oneshot_en_cleared");
    readExpect(2'd1, 32'd0, "oneshot_cnt_hold");
    clearAll();

    // COUNT write coincident with a tick
    wrReg(2'd2, 32'd50);
    wrReg(2'd1, 32'd50);
    wrReg(2'd0, 32'h0000_0203);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0);
    wrReg(2'd1, 32'd100);
    readExpect(2'd1, 32'd100, "cntwr_tick_a");
    readExpect(2'd1, 32'd100, "cntwr_tick_b");
    readExpect(2'd1, 32'd100, "cntwr_tick_c");
    readExpect(2'd1, 32'd99, "cntwr_next_dec");
    clearAll();

    // Reset mid-count
    wrReg(2'd1, 32'd5);
    wrReg(2'd0, 32'h0000_0005);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0);
    applyStimulus(1'b1, 32'd0, 32'd0, 1'b0);
    readExpect(2'd0, 32'd0, "midrst_ctrl");
    readExpect(2'd1, 32'd0, "midrst_count");
    readExpect(2'd3, 32'd0, "midrst_status");
    checkOutput("midrst_intr", {31'd0, INTR}, 32'd0);
    for (int k = 0; k < 5; k++) applyStimulus(1'b0, 32'd0, 32'd0, 1'b0);
    readExpect(2'd1, 32'd0, "midrst_no_tick");
    readExpect(2'd3, 32'd0, "midrst_no_pend");

    // Writes outside the window
    wrReg(2'd2, 32'h0000_1234);
    applyStimulus(1'b0, BASE + 32'h10, 32'hFFFF_FFFF, 1'b1);
    #1;
    checkOutput("oow_hi_hit", {31'd0, RD_HIT}, 32'd0);
    checkOutput("oow_hi_data", RD_DATA, 32'd0);
    applyStimulus(1'b0, BASE - 32'd4, 32'hFFFF_FFFF, 1'b1);
    #1;
    checkOutput("oow_lo_hit", {31'd0, RD_HIT}, 32'd0);
    checkOutput("oow_lo_data", RD_DATA, 32'd0);
    readExpect(2'd2, 32'h0000_1234, "oow_reload_kept");
    readExpect(2'd0, 32'd0, "oow_ctrl_kept");
    readExpect(2'd3, 32'd0, "oow_status_kept");

    // Randomized traffic checked by the model every cycle
    for (int n = 0; n < 3000; n++) begin
      r   = $urandom_range(0, 99);
      idx = 2'($urandom_range(0, 3));
      addr = BASE + {28'd0, idx, 2'b00} + 32'($urandom_range(0, 3));
      if (r < 2) begin
        applyStimulus(1'b1, addr, $urandom, 1'b0);
      end else if (r < 40) begin
        case (idx)
          2'd0: begin data = $urandom; data[15:8] = 8'($urandom_range(0, 3)); end
          2'd1: data = 32'($urandom_range(0, 6));
          2'd2: data = 32'($urandom_range(0, 6));
          default: data = $urandom;
        endcase
        applyStimulus(1'b0, addr, data, 1'b1);
      end else if (r < 45) begin
        addr = (r[0]) ? BASE + 32'h10 + 32'($urandom_range(0, 15))
                      : BASE - 32'd4 + 32'($urandom_range(0, 3));
        applyStimulus(1'b0, addr, $urandom, 1'b1);
      end else if (r < 50) begin
        applyStimulus(1'b0, $urandom, 32'd0, 1'b0);
      end else begin
        applyStimulus(1'b0, addr, $urandom, 1'b0);
      end
    end

    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0);
    @(posedge CLK);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/otter_io_timer.md
OTTER_IO_TIMER -- requirements
Module: otter_io_timer

Interface
REQ-001 Parameter BASE_ADDR, 32'h1100_0400, base of the 16-byte register window on the IOBUS.
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 IOBUS_ADDR  input  32  MCU IO address, valid in the cycle IOBUS_WR is sampled.
REQ-005 IOBUS_OUT  input  32  MCU write data.
REQ-006 IOBUS_WR  input  1  one-cycle write strobe from the MCU memory stage.
REQ-007 RD_DATA  output  32  read data for the MCU IOBUS_IN mux; zero when not selected.
REQ-008 RD_HIT  output  1  high when IOBUS_ADDR falls in the window.
REQ-009 INTR  output  1  level interrupt request to the MCU INTR input.

Function
REQ-010 Select = (IOBUS_ADDR[31:4] == BASE_ADDR[31:4]); register index = IOBUS_ADDR[3:2]; IOBUS_ADDR[1:0] ignored; writes are full-word only.
REQ-011 Index 0 CTRL: bit0 EN, bit1 AUTO, bit2 IE, bits[15:8] PRESCALE, other bits read 0.
REQ-012 Index 1 COUNT (32b, read/write); index 2 RELOAD (32b, read/write); index 3 STATUS: bit0 PEND, write-1-to-clear, writing 0 has no effect.
REQ-013 RD_DATA and RD_HIT are combinational from IOBUS_ADDR and the current register values; no read side effects.
REQ-014 Prescaler counter PCNT (8b) increments each cycle while EN=1; when PCNT >= PRESCALE a tick occurs and PCNT returns to 0; tick period = PRESCALE+1 cycles.
REQ-015 PRESCALE=0 gives a tick every cycle while EN=1.
REQ-016 PCNT holds at 0 while EN=0; a CTRL write sets PCNT to 0.
REQ-017 On a tick with COUNT != 0, COUNT decrements by 1 on the same edge.
REQ-018 On a tick with COUNT == 0: PEND is set; if AUTO=1, COUNT loads RELOAD; if AUTO=0, EN clears and COUNT stays 0 (one-shot).
REQ-019 INTR = PEND & IE, driven from registered bits only, glitch-free, no added latency.
REQ-020 Simultaneous software COUNT write and tick: the written value wins, no decrement, and PCNT is set to 0.
REQ-021 Simultaneous software CTRL write and hardware EN clear (REQ-018): the written value wins.
REQ-022 Simultaneous STATUS W1C and hardware PEND set: PEND ends at 1.
REQ-023 A PRESCALE reduced below the current PCNT causes a tick on the next cycle (the compare is >=, not ==).
REQ-024 A write with IOBUS_WR=1 outside the window changes no state.

Reset
REQ-025 On RST: CTRL=0, COUNT=0, RELOAD=0, PEND=0, PCNT=0; therefore INTR=0, and RD_DATA follows REQ-013 with zeroed registers.
REQ-026 RST overrides any coincident write or tick; a timer running when RST is asserted stops with no PEND set.

Structure
REQ-027 Package otter_io_pkg holds the register index constants, the CTRL bit positions, the PRESCALE field range and the default BASE_ADDR.
REQ-028 The prescaler is one sub-module, tmr_prescaler (inputs EN, CLR, PRESCALE; output TICK); the register file, decode and the countdown logic stay in otter_io_timer.

Verification
REQ-029 Write RELOAD=3, COUNT=3, CTRL=EN|AUTO|IE with PRESCALE=0 -> COUNT reads 2,1,0 on successive cycles; PEND and INTR rise on the 4th tick edge; COUNT reloads to 3; it repeats every 4 cycles.
REQ-030 Write COUNT=1, CTRL=EN|IE with PRESCALE=4 -> ticks every 5 cycles; PEND is set after 10 cycles; EN reads 0 and COUNT holds 0 afterwards.
REQ-031 With PEND=1: write STATUS=0 -> PEND stays 1; write STATUS=1 -> PEND=0 and INTR=0 next cycle; W1C in the same cycle as an expiring tick -> PEND stays 1.
REQ-032 Write COUNT=100 in the same cycle as a tick -> COUNT reads 100 and the next decrement occurs PRESCALE+1 cycles later.
REQ-033 Assert RST mid-count (COUNT=5, EN=1) -> all reads return 0 and INTR=0; no tick occurs after RST deasserts until EN is rewritten.
REQ-034 Write to BASE_ADDR+0x10 and to BASE_ADDR-4 -> no register changes; RD_HIT=0 and RD_DATA=0 at those addresses.
